// File: rtl/seg7_symbol_capture.sv
// Receive side of the PUF 7-segment link: synchronizes and debounces the active-low
// segment bus, decodes 0/1 glyphs and assembles RESP_WIDTH-bit words for a valid/ready consumer.
module seg7_symbol_capture #(
   parameter  int STABLE_CYCLES = 16,
   parameter  int RESP_WIDTH    = 8,
   localparam int BW            = $clog2(RESP_WIDTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [6:0]            seg,
   input  logic                  clear,
   output logic [RESP_WIDTH-1:0] resp_data,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic                  sym_err,
   output logic                  ovf,
   output logic [BW-1:0]         bit_count
);

   localparam int              CW   = $clog2(STABLE_CYCLES);
   localparam logic [CW-1:0]   CMAX = CW'(STABLE_CYCLES - 1);
   localparam logic [BW-1:0]   LAST = BW'(RESP_WIDTH - 1);
   localparam logic [6:0]      BLANK = 7'h7F;
   localparam logic [6:0]      ZERO  = 7'h40;
   localparam logic [6:0]      ONE   = 7'h7C;

   typedef enum logic {WAIT_BLANK, WAIT_SYM} state_t;

   state_t                state, state_nxt;
   logic [6:0]            seg_s1, seg_s2, seg_prev;
   logic [CW-1:0]         stab_cnt;
   logic                  stable, is_blank, is_zero, is_one;
   logic                  take, drop, err, hs_busy;
   logic [RESP_WIDTH-1:0] resp_shift, shift_nxt;

   // seg_prev is the previous synchronized sample; the counter tracks how long they have matched
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_s1   <= BLANK;
         seg_s2   <= BLANK;
         seg_prev <= BLANK;
         stab_cnt <= '0;
      end else begin
         seg_s1   <= seg;
         seg_s2   <= seg_s1;
         seg_prev <= seg_s2;
         if (seg_s2 != seg_prev)
            stab_cnt <= '0;
         else if (stab_cnt != CMAX)
            stab_cnt <= stab_cnt + CW'(1);
      end
   end

   assign stable   = (seg_s2 == seg_prev) && (stab_cnt == CMAX);
   assign is_blank = (seg_s2 == BLANK);
   assign is_zero  = (seg_s2 == ZERO);
   assign is_one   = (seg_s2 == ONE);
   // a word still held after this edge's handshake cannot accept another bit
   assign hs_busy  = resp_valid && !resp_ready;
   assign shift_nxt = (resp_shift << 1) | RESP_WIDTH'(is_one);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= WAIT_BLANK;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      drop      = 1'b0;
      err       = 1'b0;
      case (state)
         WAIT_BLANK: if (stable && is_blank) state_nxt = WAIT_SYM;
         WAIT_SYM: begin
            if (stable && !is_blank) begin
               state_nxt = WAIT_BLANK;
               if (is_zero || is_one) begin
                  if (hs_busy) drop = 1'b1;
                  else         take = 1'b1;
               end else begin
                  err = 1'b1;
               end
            end
         end
         default: state_nxt = WAIT_BLANK;
      endcase
      if (clear) state_nxt = WAIT_BLANK;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_shift <= '0;
         resp_data  <= '0;
         resp_valid <= 1'b0;
         sym_err    <= 1'b0;
         ovf        <= 1'b0;
         bit_count  <= '0;
      end else begin
         sym_err <= err && !clear;
         if (clear) begin
            resp_shift <= '0;
            resp_valid <= 1'b0;
            ovf        <= 1'b0;
            bit_count  <= '0;
         end else begin
            if (resp_valid && resp_ready) resp_valid <= 1'b0;
            if (drop) ovf <= 1'b1;
            if (take) begin
               resp_shift <= shift_nxt;
               if (bit_count == LAST) begin
                  resp_data  <= shift_nxt;
                  resp_valid <= 1'b1;
                  bit_count  <= '0;
               end else begin
                  bit_count <= bit_count + BW'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_seg7_symbol_capture.sv
// Bench for seg7_symbol_capture: glyph table, hand-written corner sequences and a
// randomized run checked against a per-symbol behavioural model.
module tb_seg7_symbol_capture;

   localparam int S = 4;
   localparam int W = 8;

   logic       clk = 1'b0, rst_n = 1'b0, clear = 1'b0, resp_ready = 1'b1;
   logic [6:0] seg = 7'h7F;
   logic [W-1:0] resp_data;
   logic       resp_valid, sym_err, ovf;
   logic [3:0] bit_count;

   int n_chk = 0, n_fail = 0;
   int errc = 0, vcyc = 0;

   seg7_symbol_capture #(.STABLE_CYCLES(S), .RESP_WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .seg(seg), .clear(clear),
      .resp_data(resp_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .sym_err(sym_err), .ovf(ovf), .bit_count(bit_count)
   );

   always #5 clk = ~clk;

   // per-cycle counts of sym_err and resp_valid high
   always @(posedge clk) begin
      errc <= errc + int'(sym_err);
      vcyc <= vcyc + int'(resp_valid);
   end

   typedef struct {
      logic [6:0] g;
      int         hold;
      logic [3:0] cnt;
      logic       v;
      logic [7:0] d;
      int         e;
   } vec_t;

   vec_t tbl[11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic glyph(input logic [6:0] g, input int hold);
      seg = g;
      repeat (hold) tick();
      seg = 7'h7F;
      repeat (8) tick();
   endtask

   task automatic send_bit(input logic b);
      glyph(b ? 7'h7C : 7'h40, 8);
   endtask

   task automatic send_word(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int e0, n, kind, hold;
      logic [6:0] g;
      logic       b, r;
      logic [7:0] mshift, mdata;
      int         mcnt, me;
      logic       mvalid, movf;

      tbl[0]  = '{7'h7C, 8, 4'd1, 1'b0, 8'h00, 0};
      tbl[1]  = '{7'h40, 8, 4'd2, 1'b0, 8'h00, 0};
      tbl[2]  = '{7'h7C, 8, 4'd3, 1'b0, 8'h00, 0};
      tbl[3]  = '{7'h7C, 8, 4'd4, 1'b0, 8'h00, 0};
      tbl[4]  = '{7'h40, 8, 4'd5, 1'b0, 8'h00, 0};
      tbl[5]  = '{7'h40, 8, 4'd6, 1'b0, 8'h00, 0};
      tbl[6]  = '{7'h7C, 8, 4'd7, 1'b0, 8'h00, 0};
      tbl[7]  = '{7'h40, 8, 4'd0, 1'b0, 8'hB2, 0};
      tbl[8]  = '{7'h7C, 3, 4'd0, 1'b0, 8'hB2, 0};
      tbl[9]  = '{7'h00, 8, 4'd0, 1'b0, 8'hB2, 1};
      tbl[10] = '{7'h7C, 8, 4'd1, 1'b0, 8'hB2, 0};

      // reset state
      repeat (3) tick();
      chk("rst_data", resp_data, 0);
      chk("rst_valid", resp_valid, 0);
      chk("rst_cnt", bit_count, 0);
      rst_n = 1'b1;
      repeat (8) tick();
      chk("post_rst_err", sym_err, 0);
      chk("post_rst_ovf", ovf, 0);

      // glyph table
      for (int i = 0; i < 11; i++) begin
         e0 = errc;
         glyph(tbl[i].g, tbl[i].hold);
         chk($sformatf("tbl%0d_cnt", i), bit_count, tbl[i].cnt);
         chk($sformatf("tbl%0d_valid", i), resp_valid, tbl[i].v);
         chk($sformatf("tbl%0d_data", i), resp_data, tbl[i].d);
         chk($sformatf("tbl%0d_ovf", i), ovf, 0);
         chk($sformatf("tbl%0d_err", i), errc - e0, tbl[i].e);
      end
      chk("valid_pulse_cycles", vcyc, 1);

      // acceptance latency: 2 sync + S qualify + 1 update
      seg = 7'h40;
      n = 0;
      while (bit_count == 4'd1 && n < 20) begin
         tick();
         n++;
      end
      chk("latency", n, S + 3);
      repeat (8 - n) tick();
      seg = 7'h7F;
      repeat (8) tick();

      // clear after 5 bits, then a fresh all-ones word
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      chk("pre_clear_cnt", bit_count, 5);
      pulse_clear();
      chk("clear_cnt", bit_count, 0);
      send_word(8'hFF);
      chk("ff_data", resp_data, 8'hFF);
      chk("ff_cnt", bit_count, 0);

      // overflow with consumer stalled
      resp_ready = 1'b0;
      send_word(8'h3C);
      chk("w1_valid", resp_valid, 1);
      chk("w1_data", resp_data, 8'h3C);
      chk("w1_ovf", ovf, 0);
      send_bit(1'b1);
      chk("ovf_set", ovf, 1);
      chk("ovf_cnt", bit_count, 0);
      for (int i = 0; i < 7; i++) send_bit(i[0]);
      chk("w2_data_kept", resp_data, 8'h3C);
      resp_ready = 1'b1;
      tick();
      tick();
      chk("hs_valid_low", resp_valid, 0);
      chk("hs_data_kept", resp_data, 8'h3C);
      chk("ovf_sticky", ovf, 1);
      pulse_clear();
      chk("clear_ovf", ovf, 0);

      // symbol accepted on the same edge as the handshake
      resp_ready = 1'b0;
      send_word(8'hC3);
      chk("w3_valid", resp_valid, 1);
      seg = 7'h7C;
      repeat (S + 2) tick();
      resp_ready = 1'b1;
      tick();
      chk("same_edge_cnt", bit_count, 1);
      chk("same_edge_ovf", ovf, 0);
      chk("same_edge_valid", resp_valid, 0);
      repeat (8 - (S + 3)) tick();
      seg = 7'h7F;
      repeat (8) tick();

      // asynchronous reset mid-word
      for (int i = 0; i < 3; i++) send_bit(1'b0);
      chk("pre_rst_cnt", bit_count, 4);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_data", resp_data, 0);
      chk("arst_cnt", bit_count, 0);
      chk("arst_valid", resp_valid, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (2) tick();
      send_word(8'h5A);
      chk("5a_data", resp_data, 8'h5A);
      chk("5a_cnt", bit_count, 0);

      // randomized symbols against a per-symbol model
      mdata = 8'h5A; mshift = '0; mcnt = 0; mvalid = 1'b0; movf = 1'b0;
      for (int it = 0; it < 60; it++) begin
         r = 1'($urandom_range(0, 1));
         resp_ready = r;
         if ($urandom_range(0, 9) == 0) begin
            pulse_clear();
            mshift = '0; mcnt = 0; mvalid = 1'b0; movf = 1'b0;
         end
         if (r) mvalid = 1'b0;
         kind = $urandom_range(0, 3);
         b = 1'($urandom_range(0, 1));
         hold = $urandom_range(5, 10);
         me = 0;
         case (kind)
            0, 1: g = b ? 7'h7C : 7'h40;
            2: begin
               g = 7'($urandom_range(0, 127));
               if (g == 7'h40 || g == 7'h7C || g == 7'h7F) g = 7'h00;
               me = 1;
            end
            default: begin
               g = b ? 7'h7C : 7'h40;
               hold = 3;
            end
         endcase
         e0 = errc;
         glyph(g, hold);
         if (kind < 2) begin
            if (mvalid) movf = 1'b1;
            else begin
               mshift = {mshift[6:0], b};
               mcnt++;
               if (mcnt == W) begin
                  mdata = mshift;
                  mvalid = 1'b1;
                  mcnt = 0;
               end
            end
         end
         if (r) mvalid = 1'b0;
         chk($sformatf("rnd%0d_cnt", it), bit_count, mcnt);
         chk($sformatf("rnd%0d_valid", it), resp_valid, mvalid);
         chk($sformatf("rnd%0d_data", it), resp_data, mdata);
         chk($sformatf("rnd%0d_ovf", it), ovf, movf);
         chk($sformatf("rnd%0d_err", it), errc - e0, me);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/seg7_symbol_capture.md
# seg7_symbol_capture

Receive-side counterpart of the PUF serial 7-segment encoder. It samples an active-low segment bus driven by another board's PUF display, debounces it, and decodes the two response-bit glyphs back to bits. It assembles RESP_WIDTH bits into a response word and presents that word on a valid/ready handshake to the downstream PUF comparison logic.

## Interface
- STABLE_CYCLES, default 16: number of consecutive identical synchronized samples required to accept a pattern; legal range ≥ 2.
- RESP_WIDTH, default 8: bits per response word; legal range ≥ 1.
- clk  input  1  single system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- seg  input  7  `{g,f,e,d,c,b,a}`, active-low (0 = segment lit); asynchronous to clk.
- clear  input  1  synchronous abort: drops the partial word, the valid word and the flags.
- resp_data  output  RESP_WIDTH  assembled response; first received bit ends up in the MSB.
- resp_valid  output  1  resp_data holds a complete word.
- resp_ready  input  1  consumer accepts the word.
- sym_err  output  1  one-cycle pulse when a stable, unrecognized pattern is seen.
- ovf  output  1  sticky flag: a valid symbol was dropped because the word was full.
- bit_count  output  $clog2(RESP_WIDTH+1)  bits accumulated in the current word.

## Operation
- Glyphs on seg, raw active-low value:
  - 7'h40 decodes to bit 0.
  - 7'h7C decodes to bit 1.
  - 7'h7F is blank.
  - Anything else is invalid.
- Two-flop synchronizer on seg; both stages reset to 7'h7F.
- Stability counter:
  - Clears whenever the synchronized value differs from its previous sample.
  - `stable` is asserted in every cycle where the value has been unchanged for at least STABLE_CYCLES samples.
  - The counter saturates.
- FSM states and transitions:
  - WAIT_BLANK: on stable blank, go to WAIT_SYM. Reset and clear enter this state.
  - WAIT_SYM, stable 0/1 glyph:
    - If resp_valid is low, shift the bit in (`resp_shift <= {resp_shift, bit}`), increment bit_count, and go to WAIT_BLANK.
    - If resp_valid is high, drop the bit, set ovf, and go to WAIT_BLANK.
  - WAIT_SYM, stable invalid pattern: pulse sym_err and go to WAIT_BLANK.
  - WAIT_SYM, stable blank: stay.
- A blank is mandatory between symbols, so repeated identical bits are counted once per glyph appearance.
- Word completion:
  - The edge that shifts in the RESP_WIDTH-th bit also loads resp_data with the full word.
  - On that same edge, resp_valid is set and bit_count returns to 0.
- Handshake:
  - resp_data is stable while resp_valid is high.
  - The edge with resp_valid && resp_ready clears resp_valid; resp_data keeps its value.
  - A symbol accepted on the same edge as that handshake is shifted normally and does not set ovf, because the decision uses the post-handshake state.
- clear:
  - Returns to WAIT_BLANK and zeroes the shift register, bit_count, resp_valid, sym_err and ovf.
  - Takes priority over symbol acceptance and the handshake.
  - Does not reset the synchronizer or the stability counter.
- Reset values: resp_data 0, resp_valid 0, sym_err 0, ovf 0, bit_count 0, FSM in WAIT_BLANK, stability counter 0.
- Asserting rst_n low mid-word discards everything immediately, without waiting for a clock.

## Timing
- Acceptance latency from a seg change to the bit being shifted:
  - 2 cycles of synchronizer delay.
  - Plus STABLE_CYCLES cycles for the counter to qualify the pattern.
  - Plus 1 cycle for the register update.
  - resp_valid rises on that same edge for the final bit.
- A pattern held for fewer than STABLE_CYCLES synchronized cycles is ignored completely: no shift, no sym_err.
- Minimum symbol period ≈ 2·STABLE_CYCLES cycles: the glyph plus the blank.
- sym_err is high for exactly one cycle per invalid stable pattern, and does not repeat while that pattern is held.
- resp_ready is sampled only while resp_valid is high and has no effect otherwise.

## Test plan
Parameters for all scenarios: STABLE_CYCLES=4, RESP_WIDTH=8. Each glyph is held 8 cycles and separated by 8 blank cycles.
- Sequence 1,0,1,1,0,0,1,0 with resp_ready=1 → resp_valid pulses for 1 cycle with resp_data=8'hB2; bit_count steps 1..7, then reads 0.
- 7'h7C held 3 cycles, then blank → no shift, bit_count stays 0, sym_err stays 0.
- Stable 7'h00 (all segments lit) → sym_err high for exactly 1 cycle, bit_count unchanged, next valid glyph still accepted.
- Two 8-bit words sent with resp_ready=0, then resp_ready raised → first word retained, ovf=1 after the 9th glyph, resp_data equals the first word.
- clear asserted after 5 bits → bit_count=0; the next 8 glyphs 0xFF form resp_data=8'hFF.
- rst_n dropped asynchronously mid-word → all outputs 0 immediately; after release, 8 glyphs of 8'h5A produce resp_data=8'h5A.
